mult_rom_read_arbiter: RTL
==========================

MULT_ROM_READ_ARBITER -- requirements
Module: mult_rom_read_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing the multiplier ROM read port (2..8).
REQ-002 Reset rst, synchronous, active-high; clock clk.
REQ-003 clk  in  1  rising-edge clock, shared with the ROM AXI4-Lite slave.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  NREQ  per-requester read request, held until accepted.
REQ-006 req_a  in  3*NREQ  operand a, slice i belongs to requester i.
REQ-007 req_b  in  3*NREQ  operand b, slice i belongs to requester i.
REQ-008 req_ready  out  NREQ  one-hot accept pulse.
REQ-009 rsp_valid  out  NREQ  one-hot one-cycle response strobe.
REQ-010 rsp_result  out  6  product a*b, valid with rsp_valid.
REQ-011 rsp_err  out  1  slave returned non-OKAY rresp, valid with rsp_valid.
REQ-012 m_araddr  out  32; m_arvalid  out  1; m_arready  in  1: AXI4-Lite AR channel.
REQ-013 m_rdata  in  32; m_rresp  in  2; m_rvalid  in  1; m_rready  out  1: AXI4-Lite R channel.

Function
REQ-014 The FSM SHALL have states IDLE, ADDR, DATA and RESP, with at most one transaction outstanding.
REQ-015 IDLE with any req_valid SHALL select grant g, drive req_ready[g]=1 combinationally in that cycle, latch a and b of g, and go to ADDR. Otherwise it SHALL stay in IDLE.
REQ-016 ADDR SHALL drive m_arvalid=1 and m_araddr={24'd0,a,b,2'b00}, both stable until m_arready. On m_arvalid&&m_arready it SHALL go to DATA.
REQ-017 m_arvalid SHALL NOT deassert before the handshake completes.
REQ-018 DATA SHALL drive m_rready=1. On m_rvalid it SHALL register rsp_result=m_rdata[5:0] and rsp_err=(m_rresp!=2'b00), then go to RESP.
REQ-019 m_rdata[31:6] SHALL be ignored. When rsp_err=1, rsp_result SHALL be 6'd0.
REQ-020 RESP SHALL assert rsp_valid[g] for exactly one cycle, then go to IDLE; a new grant is possible in the following cycle.
REQ-021 Latency: with m_arready=1 and m_rvalid returned one cycle after the AR handshake, the accept cycle is T, the AR handshake is T+1, R is T+2 and rsp_valid is T+3.
REQ-022 m_arvalid, m_rready, req_ready and rsp_valid SHALL all be 0 outside their states.
REQ-023 Changes to req_valid or operands after acceptance SHALL NOT affect the transaction in flight.
REQ-024 A requester withdrawing req_valid before acceptance SHALL simply not be granted; no error is raised.

Reset
REQ-025 On rst, the FSM SHALL enter IDLE and all outputs SHALL become 0, including m_araddr and rsp_result. The round-robin pointer SHALL reset to 0.
REQ-026 rst mid-transaction SHALL abandon the transaction with no rsp_valid. The ROM slave is reset by the same rst at top level.

Configuration
REQ-027 Macro MULT_ARB_ROUND_ROBIN_EN defined: the grant SHALL be the first req_valid at or after index ptr, wrapping around. ptr SHALL become g+1 mod NREQ on each accept.
REQ-028 Macro MULT_ARB_ROUND_ROBIN_EN undefined: the grant SHALL be fixed priority, lowest index wins, and no pointer register exists.

Structure
REQ-029 Package mult_rom_pkg SHALL hold the FSM state enum, the OKAY rresp constant, and an address-formation function {24'd0,a,b,2'b00}.
REQ-030 The grant selection SHALL be one sub-module, mult_arb_pick (req vector, ptr -> one-hot grant), combinational.

Verification
REQ-031 req_valid[0], a=3, b=5, arready=1 -> araddr=0x74, rsp_valid[0] at T+3, rsp_result=15, rsp_err=0.
REQ-032 a=7, b=7, arready delayed 3 cycles -> arvalid and araddr=0xFC held stable for 3 cycles, then rsp_result=49.
REQ-033 req_valid=4'b1111 held, round-robin enabled -> grants 0,1,2,3,0 in order; macro undefined -> grants 0 repeatedly.
REQ-034 m_rresp=2'b10 with m_rdata=0x3F -> rsp_err=1, rsp_result=0.
REQ-035 rst asserted in DATA state -> next cycle all outputs 0, no rsp_valid, and a fresh request completes normally.

Source files
------------

// File: rtl/mult_rom_pkg.sv
// Shared types and helpers for the multiplier-ROM read arbiter.
// Optional round-robin grant selected by MULT_ARB_ROUND_ROBIN_EN.
package mult_rom_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] RRESP_OKAY = 2'b00;

    // ROM word address: the 6-bit {a,b} index, scaled to 32-bit words.
    function automatic logic [31:0] rom_addr(input logic [2:0] a, input logic [2:0] b);
        return {24'd0, a, b, 2'b00};
    endfunction

endpackage

// File: rtl/mult_arb_pick.sv
// One-hot grant picker: first asserted request at or after ptr, wrapping.
// With ptr tied to zero this degenerates to lowest-index-wins priority.
module mult_arb_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant
);

    int   idx_s;
    logic hit_s;
    logic found_s;

    // Rotating search; found_s blocks every later candidate once one hits.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = 0;
        hit_s   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s        = (int'(ptr) + k) % NREQ;
            hit_s        = req[idx_s] & ~found_s;
            grant[idx_s] = grant[idx_s] | hit_s;
            found_s      = found_s | hit_s;
        end
    end

endmodule

// File: rtl/mult_rom_read_arbiter.sv
// Shares one AXI4-Lite read port of the multiplier ROM among NREQ requesters,
// one transaction at a time. Round-robin grant when MULT_ARB_ROUND_ROBIN_EN is defined.
module mult_rom_read_arbiter
    import mult_rom_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [3*NREQ-1:0] req_a,
    input  logic [3*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [5:0]        rsp_result,
    output logic              rsp_err,
    output logic [31:0]       m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    localparam int PTR_W = $clog2(NREQ);

    state_t            state_r;
    logic [NREQ-1:0]   grant_s;
    logic [NREQ-1:0]   grant_r;
    logic [PTR_W-1:0]  ptr_s;
    logic [2:0]        a_sel_s;
    logic [2:0]        b_sel_s;
    logic              unused_rdata_s;

    // Only the low six bits of a ROM word carry the product.
    assign unused_rdata_s = ^m_rdata[31:6];

`ifdef MULT_ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] grant_idx_s;

    assign ptr_s = ptr_r;

    // Binary index of the one-hot grant, used to advance the pointer.
    always_comb begin
        grant_idx_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_idx_s = grant_s[i] ? PTR_W'(i) : grant_idx_s;
        end
    end

    // Pointer moves just past the requester accepted this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (state_r == IDLE && (|grant_s)) begin
            ptr_r <= (grant_idx_s == PTR_W'(NREQ - 1)) ? '0 : grant_idx_s + PTR_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    assign ptr_s = '0;
`endif

    mult_arb_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_s),
        .grant (grant_s)
    );

    // Operand mux for the granted requester.
    always_comb begin
        a_sel_s = 3'd0;
        b_sel_s = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            a_sel_s = a_sel_s | (req_a[3*i +: 3] & {3{grant_s[i]}});
            b_sel_s = b_sel_s | (req_b[3*i +: 3] & {3{grant_s[i]}});
        end
    end

    // Accept is combinational so a requester learns of it in the grant cycle.
    always_comb begin
        if (state_r == IDLE && !rst) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Transaction FSM; the latched address freezes the operands at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            grant_r    <= '0;
            m_araddr   <= 32'd0;
            m_arvalid  <= 1'b0;
            m_rready   <= 1'b0;
            rsp_valid  <= '0;
            rsp_result <= 6'd0;
            rsp_err    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|grant_s) begin
                        grant_r   <= grant_s;
                        m_araddr  <= rom_addr(a_sel_s, b_sel_s);
                        m_arvalid <= 1'b1;
                        state_r   <= ADDR;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                ADDR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state_r   <= DATA;
                    end else begin
                        state_r   <= ADDR;
                    end
                end
                DATA: begin
                    if (m_rvalid) begin
                        m_rready  <= 1'b0;
                        rsp_valid <= grant_r;
                        rsp_err   <= (m_rresp != RRESP_OKAY);
                        if (m_rresp != RRESP_OKAY) begin
                            rsp_result <= 6'd0;
                        end else begin
                            rsp_result <= m_rdata[5:0];
                        end
                        state_r   <= RESP;
                    end else begin
                        state_r   <= DATA;
                    end
                end
                RESP: begin
                    rsp_valid <= '0;
                    state_r   <= IDLE;
                end
                default: begin
                    m_arvalid <= 1'b0;
                    m_rready  <= 1'b0;
                    rsp_valid <= '0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule
